// File: rtl/spell_mem_arbiter.sv
// Two-requester arbiter for the spell memory port: one grant at a time, one idle cycle after each access.
// Define SPELL_MEM_ARB_RR_EN for round-robin contention handling; otherwise req0 has fixed priority.
module spell_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_select,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data_in,
  input  logic [1:0]            req0_type,
  input  logic                  req0_write,
  output logic [DATA_WIDTH-1:0] req0_data_out,
  output logic                  req0_ready,
  input  logic                  req1_select,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data_in,
  input  logic [1:0]            req1_type,
  input  logic                  req1_write,
  output logic [DATA_WIDTH-1:0] req1_data_out,
  output logic                  req1_ready,
  output logic                  mem_select,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_type,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  output logic [1:0]            grant,
  output logic                  busy
);

  // state   | meaning
  // IDLE    | no owner, waiting for a select
  // GRANT0  | req0 owns the memory port
  // GRANT1  | req1 owns the memory port
  // RELEASE | one dead cycle that swallows the finishing requester's lingering select
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

  state_t state;
  logic   pick0;

`ifdef SPELL_MEM_ARB_RR_EN
  logic last_served;  // 1 = req1 was served last, so req0 wins the next contention
  assign pick0 = req0_select && (!req1_select || last_served);
`else
  assign pick0 = req0_select;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'b00;
      busy  <= 1'b0;
`ifdef SPELL_MEM_ARB_RR_EN
      last_served <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick0) begin
            state <= GRANT0;
            grant <= 2'b01;
            busy  <= 1'b1;
          end else if (req1_select) begin
            state <= GRANT1;
            grant <= 2'b10;
            busy  <= 1'b1;
          end
        end
        GRANT0: begin
          if (mem_data_ready || !req0_select) begin
            state <= RELEASE;
            grant <= 2'b00;
`ifdef SPELL_MEM_ARB_RR_EN
            last_served <= 1'b0;
`endif
          end
        end
        GRANT1: begin
          if (mem_data_ready || !req1_select) begin
            state <= RELEASE;
            grant <= 2'b00;
`ifdef SPELL_MEM_ARB_RR_EN
            last_served <= 1'b1;
`endif
          end
        end
        RELEASE: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_select  = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_type    = 2'b00;
    mem_write   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      GRANT0: begin
        mem_select  = req0_select;
        mem_addr    = req0_addr;
        mem_data_in = req0_data_in;
        mem_type    = req0_type;
        mem_write   = req0_write;
        req0_ready  = mem_data_ready;
      end
      GRANT1: begin
        mem_select  = req1_select;
        mem_addr    = req1_addr;
        mem_data_in = req1_data_in;
        mem_type    = req1_type;
        mem_write   = req1_write;
        req1_ready  = mem_data_ready;
      end
      default: begin
      end
    endcase
  end

  assign req0_data_out = mem_data_out;
  assign req1_data_out = mem_data_out;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Randomized bench for spell_mem_arbiter against a transaction-level ownership model.
module tb_spell_mem_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       sel [2];
  logic [7:0] addr [2];
  logic [7:0] din [2];
  logic [1:0] typ [2];
  logic       wr [2];
  logic [7:0] req0_data_out, req1_data_out;
  logic       req0_ready, req1_ready;
  logic       mem_select, mem_write;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0] mem_type, grant;
  logic       mem_data_ready, busy;

  always #5 clock = ~clock;

  spell_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req0_select(sel[0]), .req0_addr(addr[0]), .req0_data_in(din[0]), .req0_type(typ[0]),
    .req0_write(wr[0]), .req0_data_out(req0_data_out), .req0_ready(req0_ready),
    .req1_select(sel[1]), .req1_addr(addr[1]), .req1_data_in(din[1]), .req1_type(typ[1]),
    .req1_write(wr[1]), .req1_data_out(req1_data_out), .req1_ready(req1_ready),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_type(mem_type), .mem_write(mem_write), .mem_data_out(mem_data_out),
    .mem_data_ready(mem_data_ready), .grant(grant), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  // model: owner is -1 when nobody holds the port; release_gap marks the dead cycle after an access
  int owner = -1;
  bit release_gap = 0;
  bit last_was1 = 1;
  bit active [2];
  bit ready_seen [2];
  int mem_cnt = -1;
  bit starve = 0;
  int g1_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    if (sel[0] && sel[1]) begin
`ifdef SPELL_MEM_ARB_RR_EN
      return last_was1 ? 0 : 1;
`else
      return 0;
`endif
    end
    return sel[0] ? 0 : 1;
  endfunction

  task automatic model_update();
    if (reset) begin
      owner = -1; release_gap = 0; last_was1 = 1;
    end else if (owner >= 0) begin
      if (mem_data_ready || !sel[owner]) begin
        last_was1 = (owner == 1);
        owner = -1;
        release_gap = 1;
      end
    end else if (release_gap) begin
      release_gap = 0;
    end else if (sel[0] || sel[1]) begin
      owner = pick_winner();
    end
  endtask

  task automatic drive_requesters();
    for (int r = 0; r < 2; r++) begin
      if (active[r]) begin
        if (ready_seen[r]) begin
          sel[r] = 0; active[r] = 0;
        end else if (!starve && owner == r && $urandom_range(0, 15) == 0) begin
          sel[r] = 0; active[r] = 0;
        end
      end else if (starve || $urandom_range(0, 2) == 0) begin
        sel[r] = 1; active[r] = 1;
        addr[r] = 8'($urandom); din[r] = 8'($urandom);
        typ[r] = 2'($urandom); wr[r] = 1'($urandom);
      end
    end
  endtask

  task automatic drive_memory();
    mem_data_out = 8'($urandom);
    if (owner >= 0 && sel[owner]) begin
      if (mem_cnt < 0) mem_cnt = $urandom_range(0, 2);
      mem_data_ready = (mem_cnt == 0);
      mem_cnt--;
      if (mem_cnt < -1) mem_cnt = -1;
    end else begin
      mem_cnt = -1;
      mem_data_ready = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic check_outputs();
    logic [18:0] exp_fields;
    logic [1:0]  exp_grant;
    exp_grant  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    exp_fields = (owner >= 0) ? {addr[owner], din[owner], typ[owner], wr[owner]} : 19'd0;
    check_val("grant", 32'(grant), 32'(exp_grant));
    check_val("busy", 32'(busy), 32'(owner >= 0 || release_gap));
    check_val("mem_select", 32'(mem_select), 32'(owner >= 0 && sel[owner]));
    check_val("mem_fields", 32'({mem_addr, mem_data_in, mem_type, mem_write}), 32'(exp_fields));
    check_val("req0_ready", 32'(req0_ready), 32'(owner == 0 && mem_data_ready));
    check_val("req1_ready", 32'(req1_ready), 32'(owner == 1 && mem_data_ready));
    check_val("data_out0", 32'(req0_data_out), 32'(mem_data_out));
    check_val("data_out1", 32'(req1_data_out), 32'(mem_data_out));
    ready_seen[0] = req0_ready;
    ready_seen[1] = req1_ready;
    if (starve && grant == 2'b10) g1_count++;
  endtask

  task automatic run_cycle(input bit rst);
    reset = rst;
    drive_requesters();
    drive_memory();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1;
    mem_data_ready = 0;
    mem_data_out = 0;
    for (int r = 0; r < 2; r++) begin
      sel[r] = 0; addr[r] = 0; din[r] = 0; typ[r] = 0; wr[r] = 0;
      active[r] = 0; ready_seen[r] = 0;
    end
    @(posedge clock);
    model_update();
    #1;
    reset = 0;
    @(negedge clock);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_mem_select", 32'(mem_select), 32'd0);
    @(posedge clock);
    model_update();
    #1;

    for (int c = 0; c < 3000; c++) run_cycle($urandom_range(0, 199) == 0);

    starve = 1;
    for (int c = 0; c < 12; c++) run_cycle(0);
    g1_count = 0;
    for (int c = 0; c < 24; c++) run_cycle(0);
`ifdef SPELL_MEM_ARB_RR_EN
    check_val("rr_req1_served", 32'(g1_count != 0), 32'd1);
`else
    check_val("starve_req1_grants", 32'(g1_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
